bf_mem_arbiter: RTL and testbench

Shares one single-port, synchronous-read SRAM between the BF core's instruction fetch and data accesses. This replaces the separate program and data memories in the chip build. Program bytes occupy the lower half of the memory and the tape occupies the upper half. The block also sequences zero-clearing of the tape after reset or on command, and holds off core requests until clearing is done.

---
 rtl/bf_mem_pkg.sv | 31 +++
 rtl/bf_rr_arb2.sv | 43 ++++
 rtl/bf_mem_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_bf_mem_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bf_mem_pkg.sv
// Shared types and helpers for the BF single-SRAM memory arbiter.
// Program bytes live in the lower half of the SRAM, the tape in the upper half.
package bf_mem_pkg;

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        ISSUE,
        COMPLETE
    } state_t;

    typedef enum logic {
        GRANT_FETCH,
        GRANT_DATA
    } grant_t;

    // Widest supported port address; the top truncates the mapped result to its own width.
    localparam int unsigned MAP_AW = 32;

    function automatic logic [MAP_AW:0] map_addr(
        input logic              is_data,
        input logic [MAP_AW-1:0] addr,
        input int unsigned       msb
    );
        logic [MAP_AW:0] r;
        r      = {1'b0, addr};
        r[msb] = is_data;
        return r;
    endfunction

endpackage

// File: rtl/bf_rr_arb2.sv
// Two-requester arbiter: a lone request wins outright, a tie goes to the requester
// that did not win the previous tie.
module bf_rr_arb2
    import bf_mem_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic req_fetch,
    input  logic req_data,
    input  logic accept,
    output logic gnt_valid,
    output logic gnt_data
);

    grant_t last_grant_q;
    grant_t last_grant_d;
    grant_t gnt;

    always_comb begin
        gnt_valid = req_fetch | req_data;
        if (req_fetch && req_data) begin
            gnt = (last_grant_q == GRANT_DATA) ? GRANT_FETCH : GRANT_DATA;
        end else begin
            gnt = req_data ? GRANT_DATA : GRANT_FETCH;
        end
        // History only moves when a contested grant is actually taken.
        last_grant_d = last_grant_q;
        if (accept && req_fetch && req_data) begin
            last_grant_d = gnt;
        end
    end

    assign gnt_data = (gnt == GRANT_DATA);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_grant_q <= GRANT_DATA;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/bf_mem_arbiter.sv
// Shares one synchronous-read SRAM between BF instruction fetch and tape accesses,
// and sweeps the tape to zero after reset or on request.
module bf_mem_arbiter
    import bf_mem_pkg::*;
#(
    parameter int unsigned  PROG_ADDR_SIZE = 16,
    parameter int unsigned  DATA_ADDR_SIZE = 16,
    parameter bit           CLEAR_ON_RESET = 1'b1,
    localparam int unsigned MEM_ADDR_SIZE  =
        ((PROG_ADDR_SIZE > DATA_ADDR_SIZE) ? PROG_ADDR_SIZE : DATA_ADDR_SIZE) + 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      fetch_req,
    input  logic [PROG_ADDR_SIZE-1:0] fetch_addr,
    output logic [7:0]                fetch_data,
    output logic                      fetch_done,
    input  logic                      data_req,
    input  logic                      data_we,
    input  logic [DATA_ADDR_SIZE-1:0] data_addr,
    input  logic [7:0]                data_wdata,
    output logic [7:0]                data_rdata,
    output logic                      data_done,
    input  logic                      clear_start,
    output logic                      ready,
    output logic [MEM_ADDR_SIZE-1:0]  mem_addr,
    output logic [7:0]                mem_wdata,
    output logic                      mem_we,
    output logic                      mem_re,
    input  logic [7:0]                mem_rdata
);

    localparam state_t RESET_STATE = CLEAR_ON_RESET ? CLEAR : IDLE;

    state_t                    state_q, state_d;
    logic [DATA_ADDR_SIZE-1:0] cnt_q, cnt_d;
    logic                      clear_pending_q, clear_pending_d;
    logic                      ready_q, ready_d;
    grant_t                    gnt_q, gnt_d;
    logic                      we_q, we_d;
    logic [MEM_ADDR_SIZE-1:0]  mem_addr_q, mem_addr_d;
    logic [7:0]                mem_wdata_q, mem_wdata_d;
    logic                      mem_we_q, mem_we_d;
    logic                      mem_re_q, mem_re_d;
    logic                      fetch_done_q, fetch_done_d;
    logic                      data_done_q, data_done_d;
    logic [7:0]                fetch_data_q, fetch_data_d;
    logic [7:0]                data_rdata_q, data_rdata_d;

    logic   arb_valid;
    logic   arb_gnt_data;
    logic   arb_accept;
    grant_t arb_gnt;
    logic   grant_we;

    bf_rr_arb2 u_arb (
        .clock     (clock),
        .reset     (reset),
        .req_fetch (fetch_req),
        .req_data  (data_req),
        .accept    (arb_accept),
        .gnt_valid (arb_valid),
        .gnt_data  (arb_gnt_data)
    );

    assign arb_gnt  = arb_gnt_data ? GRANT_DATA : GRANT_FETCH;
    assign grant_we = arb_gnt_data & data_we;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        clear_pending_d = clear_pending_q | (clear_start & (state_q != CLEAR));
        gnt_d           = gnt_q;
        we_d            = we_q;
        mem_addr_d      = mem_addr_q;
        mem_wdata_d     = mem_wdata_q;
        mem_we_d        = 1'b0;
        mem_re_d        = 1'b0;
        fetch_done_d    = 1'b0;
        data_done_d     = 1'b0;
        fetch_data_d    = fetch_data_q;
        data_rdata_d    = data_rdata_q;
        arb_accept      = 1'b0;

        case (state_q)
            CLEAR: begin
                clear_pending_d = 1'b0;
                mem_we_d        = 1'b1;
                mem_wdata_d     = '0;
                mem_addr_d      = MEM_ADDR_SIZE'(map_addr(1'b1, MAP_AW'(cnt_q), MEM_ADDR_SIZE - 1));
                cnt_d           = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (clear_pending_q) begin
                    clear_pending_d = 1'b0;
                    cnt_d           = '0;
                    state_d         = CLEAR;
                end else if (arb_valid) begin
                    arb_accept = 1'b1;
                    gnt_d      = arb_gnt;
                    we_d       = grant_we;
                    state_d    = ISSUE;
                    mem_we_d   = grant_we;
                    mem_re_d   = ~grant_we;
                    if (arb_gnt_data) begin
                        mem_addr_d = MEM_ADDR_SIZE'(map_addr(1'b1, MAP_AW'(data_addr), MEM_ADDR_SIZE - 1));
                    end else begin
                        mem_addr_d = MEM_ADDR_SIZE'(map_addr(1'b0, MAP_AW'(fetch_addr), MEM_ADDR_SIZE - 1));
                    end
                    if (grant_we) begin
                        mem_wdata_d = data_wdata;
                    end
                end
            end
            ISSUE: begin
                state_d      = COMPLETE;
                fetch_done_d = (gnt_q == GRANT_FETCH);
                data_done_d  = (gnt_q == GRANT_DATA);
            end
            COMPLETE: begin
                state_d = IDLE;
                if (gnt_q == GRANT_FETCH) begin
                    fetch_data_d = mem_rdata;
                end else if (!we_q) begin
                    data_rdata_d = mem_rdata;
                end
            end
        endcase

        // Hold ready low for one extra cycle after the sweep so it rises only after
        // the last clearing write has been presented to the SRAM.
        ready_d = (state_q != CLEAR) && (state_d != CLEAR) && !clear_pending_d;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= RESET_STATE;
            cnt_q           <= '0;
            clear_pending_q <= 1'b0;
            ready_q         <= 1'b0;
            gnt_q           <= GRANT_FETCH;
            we_q            <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            mem_we_q        <= 1'b0;
            mem_re_q        <= 1'b0;
            fetch_done_q    <= 1'b0;
            data_done_q     <= 1'b0;
            fetch_data_q    <= '0;
            data_rdata_q    <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            clear_pending_q <= clear_pending_d;
            ready_q         <= ready_d;
            gnt_q           <= gnt_d;
            we_q            <= we_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
            mem_we_q        <= mem_we_d;
            mem_re_q        <= mem_re_d;
            fetch_done_q    <= fetch_done_d;
            data_done_q     <= data_done_d;
            fetch_data_q    <= fetch_data_d;
            data_rdata_q    <= data_rdata_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;
    assign ready     = ready_q;
    assign fetch_done = fetch_done_q;
    assign data_done  = data_done_q;
    // SRAM read data only lands in the done cycle, so it is forwarded then and the
    // captured copy is held afterwards.
    assign fetch_data = fetch_done_q ? mem_rdata : fetch_data_q;
    assign data_rdata = (data_done_q && !we_q) ? mem_rdata : data_rdata_q;

endmodule

// File: tb/tb_bf_mem_arbiter.sv
// Directed and randomized checks of bf_mem_arbiter against a shadow program/tape
// model and a tie-history round-robin model, with a behavioural SRAM attached.
module tb_bf_mem_arbiter;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       fetch_req = 1'b0;
    logic [3:0] fetch_addr = '0;
    logic [7:0] fetch_data;
    logic       fetch_done;
    logic       data_req = 1'b0;
    logic       data_we = 1'b0;
    logic [3:0] data_addr = '0;
    logic [7:0] data_wdata = '0;
    logic [7:0] data_rdata;
    logic       data_done;
    logic       clear_start = 1'b0;
    logic       ready;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic       mem_re;
    logic [7:0] mem_rdata;

    logic       pre_en = 1'b0;
    logic [4:0] pre_addr = '0;
    logic [7:0] pre_data = '0;
    logic [7:0] sram [32];

    logic [7:0] prog_m [16];
    logic [7:0] tape_m [16];
    bit         last_was_data = 1'b1;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    bf_mem_arbiter #(
        .PROG_ADDR_SIZE (4),
        .DATA_ADDR_SIZE (4),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_data  (fetch_data),
        .fetch_done  (fetch_done),
        .data_req    (data_req),
        .data_we     (data_we),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_rdata  (data_rdata),
        .data_done   (data_done),
        .clear_start (clear_start),
        .ready       (ready),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_re      (mem_re),
        .mem_rdata   (mem_rdata)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (pre_en) sram[pre_addr] <= pre_data;
        else if (mem_we) sram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= sram[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_we"}, mem_we, 0);
        check({tag, "_mem_re"}, mem_re, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_ready"}, ready, 0);
        check({tag, "_fdone"}, fetch_done, 0);
        check({tag, "_ddone"}, data_done, 0);
        check({tag, "_fdata"}, fetch_data, 0);
        check({tag, "_drdata"}, data_rdata, 0);
    endtask

    // Expect 16 zero writes to 0x10..0x1F, then ready one cycle after the last write.
    task automatic sweep(input string tag, input int pulse_at);
        int waited = 0;
        while (mem_we !== 1'b1 && waited < 6) begin
            check({tag, "_wait_ready"}, ready, 0);
            tick();
            waited++;
        end
        check({tag, "_start"}, mem_we, 1);
        for (int k = 0; k < 16; k++) begin
            check({tag, "_we"}, mem_we, 1);
            check({tag, "_addr"}, mem_addr, 32'(16 + k));
            check({tag, "_wdata"}, mem_wdata, 0);
            check({tag, "_no_re"}, mem_re, 0);
            check({tag, "_ready_low"}, ready, 0);
            if (k == pulse_at) clear_start = 1'b1;
            tick();
            clear_start = 1'b0;
        end
        check({tag, "_ready_high"}, ready, 1);
        check({tag, "_we_end"}, mem_we, 0);
        for (int i = 0; i < 16; i++) tape_m[i] = 8'h00;
    endtask

    // Uncontested access issued from IDLE: strobe next cycle, done the cycle after.
    task automatic access(input bit is_data, input bit we, input logic [3:0] a, input logic [7:0] wd);
        logic [7:0] exp_rd;
        exp_rd = is_data ? tape_m[a] : prog_m[a];
        if (is_data) begin
            data_req = 1'b1; data_we = we; data_addr = a; data_wdata = wd;
        end else begin
            fetch_req = 1'b1; fetch_addr = a;
        end
        tick();
        check("acc_addr", mem_addr, {is_data, a});
        check("acc_we", mem_we, we);
        check("acc_re", mem_re, !we);
        if (we) check("acc_wdata", mem_wdata, wd);
        check("acc_early_done", fetch_done | data_done, 0);
        tick();
        check("acc_fdone", fetch_done, !is_data);
        check("acc_ddone", data_done, is_data);
        if (!we) check("acc_rdata", is_data ? data_rdata : fetch_data, exp_rd);
        fetch_req = 1'b0;
        data_req  = 1'b0;
        if (we) tape_m[a] = wd;
        tick();
        check("acc_done_low", fetch_done | data_done, 0);
        if (!we) check("acc_hold", is_data ? data_rdata : fetch_data, exp_rd);
    endtask

    // Both requesters raised together; keep=1 re-requests after each done.
    task automatic pair(input logic [3:0] fa, input logic [3:0] da, input bit dwe,
                        input logic [7:0] dwd, input bit keep, input int n);
        bit f_on = 1'b1;
        bit d_on = 1'b1;
        fetch_req = 1'b1; fetch_addr = fa;
        data_req = 1'b1; data_we = dwe; data_addr = da; data_wdata = dwd;
        for (int g = 0; g < n; g++) begin
            bit exp_data;
            int waited = 0;
            if (f_on && d_on) begin
                exp_data = !last_was_data;
                last_was_data = exp_data;
            end else begin
                exp_data = d_on;
            end
            do begin
                tick();
                waited++;
            end while (!(fetch_done || data_done) && waited < 8);
            check("pair_gap", waited, (g == 0) ? 2 : 3);
            check("pair_who", data_done, exp_data);
            check("pair_single_done", fetch_done & data_done, 0);
            if (exp_data) begin
                if (!dwe) check("pair_rdata", data_rdata, tape_m[da]);
                else tape_m[da] = dwd;
            end else begin
                check("pair_fdata", fetch_data, prog_m[fa]);
            end
            if (!keep) begin
                if (exp_data) begin data_req = 1'b0; d_on = 1'b0; end
                else begin fetch_req = 1'b0; f_on = 1'b0; end
            end
        end
        fetch_req = 1'b0;
        data_req  = 1'b0;
        tick();
        check("pair_idle", fetch_done | data_done, 0);
    endtask

    initial begin
        int w;
        #1 reset = 1'b0;
        #2;
        check_all_zero("reset");

        for (int i = 0; i < 32; i++) begin
            pre_en = 1'b1;
            pre_addr = 5'(i);
            if (i == 3) pre_data = 8'h2B;
            else if (i < 16) pre_data = 8'($urandom);
            else pre_data = 8'hEE;
            if (i < 16) prog_m[i] = pre_data;
            tick();
        end
        pre_en = 1'b0;
        check("reset_ready_held", ready, 0);
        reset = 1'b1;
        sweep("por_sweep", -1);

        // Fetch of a preloaded instruction.
        fetch_req = 1'b1; fetch_addr = 4'd3;
        tick();
        check("f3_re", mem_re, 1);
        check("f3_addr", mem_addr, 5'h03);
        check("f3_done_early", fetch_done, 0);
        tick();
        check("f3_done", fetch_done, 1);
        check("f3_data", fetch_data, 8'h2B);
        check("f3_no_ddone", data_done, 0);
        fetch_req = 1'b0;
        tick();
        check("f3_done_once", fetch_done, 0);

        // Tape write then read-back.
        access(1'b1, 1'b1, 4'd5, 8'hA7);
        access(1'b1, 1'b0, 4'd5, 8'h00);
        check("tape5_rdata", data_rdata, 8'hA7);

        // Contested requests alternate starting with fetch.
        pair(4'd3, 4'd5, 1'b0, 8'h00, 1'b1, 4);

        // Clear requested while a write is in ISSUE; a fetch waits behind the sweep.
        data_req = 1'b1; data_we = 1'b1; data_addr = 4'd9; data_wdata = 8'h5C;
        tick();
        check("cw_we", mem_we, 1);
        check("cw_addr", mem_addr, 5'h19);
        clear_start = 1'b1;
        fetch_req = 1'b1; fetch_addr = 4'd7;
        tick();
        clear_start = 1'b0;
        check("cw_ddone", data_done, 1);
        check("cw_ready_drop", ready, 0);
        data_req = 1'b0;
        tick();
        sweep("cmd_sweep", 8);
        w = 0;
        while (fetch_done !== 1'b1 && w < 6) begin tick(); w++; end
        check("pend_fdone", fetch_done, 1);
        check("pend_fdata", fetch_data, prog_m[7]);
        fetch_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("no_resweep_we", mem_we, 0);
            check("no_resweep_ready", ready, 1);
        end
        access(1'b1, 1'b0, 4'd9, 8'h00);

        // Reset in the middle of a sweep, then the sweep restarts from the bottom.
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        w = 0;
        while (!(mem_we === 1'b1 && mem_addr === 5'h17) && w < 30) begin tick(); w++; end
        check("mid_clear_reached", mem_addr, 5'h17);
        reset = 1'b0;
        #1;
        check_all_zero("mid_reset");
        tick();
        tick();
        check("mid_reset_ready", ready, 0);
        reset = 1'b1;
        last_was_data = 1'b1;
        sweep("rst_sweep", -1);

        // Randomized traffic against the shadow model.
        for (int t = 0; t < 30; t++) begin
            int kind;
            kind = int'($urandom_range(0, 2));
            if (kind == 0) access(1'b0, 1'b0, 4'($urandom), 8'h00);
            else if (kind == 1) access(1'b1, 1'($urandom), 4'($urandom), 8'($urandom));
            else pair(4'($urandom), 4'($urandom), 1'($urandom), 8'($urandom), 1'b0, 2);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

endmodule
